// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM state encoding and the default response latency.
package dmem_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int DMEM_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Size code 2'b11 has no meaning on the bus and is reported as an error.
    function automatic logic size_illegal(input logic [1:0] size);
        return (size != SIZE_B) && (size != SIZE_H) && (size != SIZE_W);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: builds the store byte mask and
// lane-replicated store data, extracts and extends load data from the read
// word, and flags half/word accesses that are not naturally aligned.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_unsigned,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    // Decode lanes per size; the read word is shifted so the addressed
    // byte/half lands at bit 0 before extension.
    always_comb begin
        wmask      = 4'b0000;
        wdata_lane = '0;
        load_data  = '0;
        misalign   = 1'b0;
        shifted    = rword >> {addr_lo, 3'b000};
        case (size)
            SIZE_B: begin
                wmask      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = load_unsigned ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
                load_data  = load_unsigned ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                wmask      = 4'b1111;
                wdata_lane = wdata;
                misalign   = |addr_lo;
                load_data  = shifted;
            end
            default: begin
                wmask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store per
// handshake and answers with a one-cycle registered response LATENCY edges
// later. Stores commit and loads read on that response edge; the memory is
// four byte-wide lanes so partial stores need no read-modify-write.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = DMEM_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic        cap_wen_reg;
    logic [31:0] cap_addr_reg;
    logic [31:0] cap_wdata_reg;
    logic [1:0]  cap_size_reg;
    logic        cap_unsigned_reg;

    logic        accept;
    logic        in_resp;
    logic [31:0] rd_word;
    logic [3:0]  wmask;
    logic [31:0] wdata_lane;
    logic [31:0] load_data;
    logic        misalign;
    logic        range_err;
    logic        req_err;
    logic        commit;

    assign req_ready = reset && (state_reg == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_resp   = (state_reg == RESP);

    // The RESP state is the cycle before the response edge, so the edge that
    // leaves RESP registers the response and the responder is ready again
    // while that response is visible.
    assign range_err = |cap_addr_reg[31:ADDR_WIDTH+2];
    assign req_err   = size_illegal(cap_size_reg) || misalign || range_err;
    assign commit    = in_resp && cap_wen_reg && !req_err;

    // State and latency counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: count down the wait cycles so RESP is occupied exactly
    // during the cycle ending at acceptance edge + LATENCY.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = CNT_LOAD;
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance; the bus need not hold it afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_wen_reg      <= 1'b0;
            cap_addr_reg     <= '0;
            cap_wdata_reg    <= '0;
            cap_size_reg     <= SIZE_B;
            cap_unsigned_reg <= 1'b0;
        end else if (accept) begin
            cap_wen_reg      <= req_wen;
            cap_addr_reg     <= req_addr;
            cap_wdata_reg    <= req_wdata;
            cap_size_reg     <= req_size;
            cap_unsigned_reg <= req_unsigned;
        end
    end

    // Memory only changes on commit edges, which never coincide with an
    // acceptance, so reading at acceptance returns the same word as reading
    // at the response edge while keeping the RAM read registered.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            // One byte lane: write on commit, registered read on acceptance.
            always_ff @(posedge clk) begin
                if (commit && wmask[gi]) begin
                    mem[cap_addr_reg[ADDR_WIDTH+1:2]] <= wdata_lane[8*gi +: 8];
                end
                if (accept) begin
                    rd_byte_reg <= mem[req_addr[ADDR_WIDTH+1:2]];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    dmem_lane_align u_align (
        .size          (cap_size_reg),
        .addr_lo       (cap_addr_reg[1:0]),
        .load_unsigned (cap_unsigned_reg),
        .rword         (rd_word),
        .wdata         (cap_wdata_reg),
        .wmask         (wmask),
        .wdata_lane    (wdata_lane),
        .load_data     (load_data),
        .misalign      (misalign)
    );

    // Response register: a single-cycle pulse; data is zero for stores and errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= in_resp;
            resp_err   <= in_resp && req_err;
            resp_rdata <= (in_resp && !req_err && !cap_wen_reg) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a byte-array
// reference model; a second LATENCY=1 instance checks the faster cadence.
module tb_dmem_responder;

    localparam int L0 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        valid1, ready1, rvalid1, rerr1;
    logic [31:0] rdata1;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] model_mem [4096];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(L0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(valid1), .req_ready(ready1), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(rvalid1), .resp_rdata(rdata1), .resp_err(rerr1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    endtask

    // Reference: naturally aligned accesses inside 4 KiB, size 3 illegal;
    // memory is a flat little-endian byte array.
    function automatic void model(input logic wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] size,
                                  input logic uns, output logic err,
                                  output logic [31:0] rd);
        int unsigned n;
        logic [31:0] v;
        n   = 1 << size;
        err = (size == 2'd3) || (addr % n != 0) || (addr >= 32'd4096);
        rd  = '0;
        if (err) return;
        if (wen) begin
            for (int i = 0; i < n; i++) model_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[addr + i];
            if (n < 4 && !uns && v[8*n-1]) begin
                for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
            end
            rd = v;
        end
    endfunction

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input string tag,
                          output logic [31:0] got_rd, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          k;
        model(wen, addr, wdata, size, uns, exp_err, exp_rd);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        chk({tag, "_ready"}, 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!resp_valid && k < 20);
        got_rd = resp_rdata;
        got_err = resp_err;
        chk({tag, "_lat"}, k, L0);
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        $display("txn %s wen=%0d addr=%08h size=%0d uns=%0d -> rdata=%08h err=%0d lat=%0d",
                 tag, wen, addr, size, uns, resp_rdata, resp_err, k);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(resp_valid), 0);
    endtask

    task automatic thru(input int inst);
        int          lat;
        int          acc[3];
        int          rsp[3];
        int          na, nr;
        logic [31:0] addrs[3];
        logic [31:0] exp_q[$];
        logic [31:0] x;
        logic        e, rdy, rv, took;
        lat = (inst == 0) ? L0 : 1;
        na = 0; nr = 0;
        addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18;
        req_wen = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = addrs[0];
        if (inst == 0) req_valid = 1'b1; else valid1 = 1'b1;
        for (int c = 0; c < 30 && nr < 3; c++) begin
            rdy = (inst == 0) ? req_ready : ready1;
            took = 1'b0;
            if (rdy && na < 3 && ((inst == 0) ? req_valid : valid1)) begin
                acc[na] = cyc + 1;
                if (inst == 0) begin
                    model(1'b0, req_addr, 32'h0, 2'b10, 1'b0, e, x);
                    exp_q.push_back(x);
                end
                na++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                chk("tp_busy", 32'((inst == 0) ? req_ready : ready1), 0);
                if (na < 3) req_addr = addrs[na];
                else begin req_valid = 1'b0; valid1 = 1'b0; end
            end
            rv = (inst == 0) ? resp_valid : rvalid1;
            if (rv && nr < 3) begin
                rsp[nr] = cyc;
                chk("tp_err", 32'((inst == 0) ? resp_err : rerr1), 0);
                if (inst == 0 && exp_q.size() > 0) chk("tp_rdata", resp_rdata, exp_q.pop_front());
                nr++;
            end
        end
        req_valid = 1'b0; valid1 = 1'b0;
        chk("tp_naccept", na, 3);
        chk("tp_nresp", nr, 3);
        for (int i = 1; i < na; i++) chk("tp_gap", acc[i] - acc[i-1], lat + 1);
        for (int i = 0; i < na && i < nr; i++) chk("tp_lat", rsp[i] - acc[i], lat);
        $display("txn throughput inst=%0d accepts=%0d responses=%0d", inst, na, nr);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        er, w, seen;
        logic [1:0]  sz;

        reset = 1'b0; req_valid = 1'b0; valid1 = 1'b0; req_wen = 1'b0;
        req_addr = '0; req_wdata = '0; req_size = 2'b00; req_unsigned = 1'b0;
        for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", 32'(resp_err), 0);
        reset = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 1);

        // Give the region used by the tests defined contents.
        for (int i = 0; i < 256; i += 4) do_req(1'b1, 32'(i), $urandom, 2'b10, 1'b0, "init", rd, er);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, "sw", rd, er);
        chk("sw_rd0", rd, 0);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "lw", rd, er);
        chk("lw_val", rd, 32'hDEADBEEF);

        do_req(1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, "sb", rd, er);
        do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, "lb", rd, er);
        chk("lb_val", rd, 32'hFFFFFF80);
        do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, "lbu", rd, er);
        chk("lbu_val", rd, 32'h00000080);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "lw2", rd, er);
        chk("lw2_val", rd, 32'h80ADBEEF);
        do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, "lhu", rd, er);
        chk("lhu_val", rd, 32'h000080AD);
        do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, "lh", rd, er);
        chk("lh_val", rd, 32'hFFFF80AD);

        do_req(1'b1, 32'h11, 32'h0000AAAA, 2'b01, 1'b0, "sh_mis", rd, er);
        chk("sh_mis_err", 32'(er), 1);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "lw3", rd, er);
        chk("lw3_val", rd, 32'h80ADBEEF);
        do_req(1'b0, 32'h12, 32'h0, 2'b10, 1'b0, "lw_mis", rd, er);
        chk("lw_mis_err", 32'(er), 1);

        do_req(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, "lw_range", rd, er);
        chk("lw_range_err", 32'(er), 1);
        do_req(1'b1, 32'h1004, 32'hFFFFFFFF, 2'b10, 1'b0, "sw_range", rd, er);
        do_req(1'b1, 32'h0, 32'hFFFFFFFF, 2'b11, 1'b0, "s_size3", rd, er);
        chk("size3_err", 32'(er), 1);
        do_req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, "lw0", rd, er);
        do_req(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, "lw4", rd, er);

        // Reset while a store sits in RESP: it must vanish without trace.
        do_req(1'b1, 32'h20, 32'h0, 2'b10, 1'b0, "sw_zero", rd, er);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h12345678; req_size = 2'b10; req_unsigned = 1'b0;
        chk("rm_ready_pre", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rm_valid", 32'(resp_valid), 0);
        chk("rm_ready", 32'(req_ready), 0);
        chk("rm_rdata", resp_rdata, 0);
        chk("rm_err", 32'(resp_err), 0);
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        chk("rm_no_pulse", 32'(seen), 0);
        chk("rm_ready_after", 32'(req_ready), 1);
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, "lw_after_rst", rd, er);
        chk("rm_lw_val", rd, 32'h0);

        thru(0);
        thru(1);

        for (int t = 0; t < 80; t++) begin
            w  = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) a = a + 32'h1000;
            do_req(w, a, $urandom, sz, 1'($urandom), "rnd", rd, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
